arb_rr_n: RTL and testbench

ARB_RR_N -- requirements
Module: arb_rr_n

---
 rtl/arb_pkg.sv | 23 ++
 rtl/arb_sync.sv | 33 +++
 rtl/arb_rr_n.sv | 133 +++++++++++++
 tb/tb_arb_rr_n.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-phase request arbiter.
// Latency: none (package only).
// Backpressure: none (package only).
package arb_pkg;

    // Arbitration policy selectors for the MODE parameter.
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Handshake state of the arbiter towards the next tier.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Width of an index into n channels; never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_sync.sv
// Multi-flop synchroniser for a bus of independent asynchronous levels.
// Latency: STAGES clk cycles from input change to q.
// Backpressure: none; every bit is resampled each cycle.
module arb_sync #(
    parameter int   WIDTH   = 1,
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the asynchronous level through the flop chain; reset to the idle level.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= {WIDTH{RST_VAL}};
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/arb_rr_n.sv
// N-channel 4-phase arbiter merging requests onto one upstream 4-phase link (cascadable).
// Latency: SYNC_STAGES+1 cycles from a request edge to ro when idle.
// Backpressure: one grant in flight; others wait in IDLE, stale upstream ack blocks grants.
module arb_rr_n
    import arb_pkg::*;
#(
    parameter int  N           = 12,
    parameter int  MODE        = MODE_RR,
    parameter int  SYNC_STAGES = 2,
    localparam int AW          = addr_width(N)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [N-1:0]  lni,
    output logic [N-1:0]  n_lno,
    output logic          ro,
    input  logic          n_ri,
    output logic [AW-1:0] addr_o
);

    logic [N-1:0]  lni_s;
    logic          n_ri_s;

    arb_state_t    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          ro_q, ro_d;
    logic [N-1:0]  n_lno_q, n_lno_d;

    logic          win_vld;
    logic [AW-1:0] win_idx;
    logic [AW-1:0] cand_idx;
    int            cand;

    // Requests idle low, the upstream acknowledge idles high.
    arb_sync #(.WIDTH(N), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_lni (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (lni),
        .q     (lni_s)
    );

    arb_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ri (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (n_ri),
        .q     (n_ri_s)
    );

    // Winner search: scan upward from the rotate pointer (or from 0), wrapping at N.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand = (MODE == MODE_RR) ? int'(ptr_q) + i : i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = AW'(cand);
            if (!win_vld && lni_s[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    // Handshake sequencing; the winner is captured once and frozen until IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (n_ri_s && win_vld) begin
                    state_d = GRANT;
                    addr_d  = win_idx;
                    if (MODE == MODE_RR) begin
                        ptr_d = (int'(win_idx) == N - 1) ? '0 : win_idx + AW'(1);
                    end
                end
            end
            GRANT: begin
                if (!n_ri_s) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!lni_s[addr_q]) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (n_ri_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    always_comb begin
        ro_d    = (state_d == GRANT) || (state_d == ACK);
        n_lno_d = '1;
        if (state_d == ACK) begin
            n_lno_d[addr_d] = 1'b0;
        end
    end

    // State and registered outputs; reset clears everything without waiting for clk.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            ro_q    <= 1'b0;
            n_lno_q <= '1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            ro_q    <= ro_d;
            n_lno_q <= n_lno_d;
        end
    end

    assign ro     = ro_q;
    assign n_lno  = n_lno_q;
    assign addr_o = addr_q;

endmodule

// File: tb/tb_arb_rr_n.sv
// Directed and randomized checks of arb_rr_n: rotate and fixed instances plus a 3-instance cascade.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_arb_rr_n;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    // Index 0: round-robin instance, index 1: fixed-priority instance.
    logic [11:0] lni_v  [2];
    logic        n_ri_v [2];
    logic [11:0] nlno_v [2];
    logic        ro_v   [2];
    logic [3:0]  addr_v [2];

    arb_rr_n #(.N(12), .MODE(1), .SYNC_STAGES(2)) u_rr (
        .clk(clk), .n_rst(n_rst), .lni(lni_v[0]), .n_lno(nlno_v[0]),
        .ro(ro_v[0]), .n_ri(n_ri_v[0]), .addr_o(addr_v[0])
    );

    arb_rr_n #(.N(12), .MODE(0), .SYNC_STAGES(2)) u_fp (
        .clk(clk), .n_rst(n_rst), .lni(lni_v[1]), .n_lno(nlno_v[1]),
        .ro(ro_v[1]), .n_ri(n_ri_v[1]), .addr_o(addr_v[1])
    );

    // Cascade: two 12-channel leaves feeding a 2-channel root.
    logic [11:0] ca_lni, cb_lni, ca_nlno, cb_nlno;
    logic        ca_ro, cb_ro;
    logic [3:0]  ca_addr, cb_addr;
    logic [1:0]  cc_nlno;
    logic        cc_ro, cc_nri;
    logic [0:0]  cc_addr;

    arb_rr_n #(.N(12), .MODE(1), .SYNC_STAGES(2)) u_ca (
        .clk(clk), .n_rst(n_rst), .lni(ca_lni), .n_lno(ca_nlno),
        .ro(ca_ro), .n_ri(cc_nlno[0]), .addr_o(ca_addr)
    );

    arb_rr_n #(.N(12), .MODE(1), .SYNC_STAGES(2)) u_cb (
        .clk(clk), .n_rst(n_rst), .lni(cb_lni), .n_lno(cb_nlno),
        .ro(cb_ro), .n_ri(cc_nlno[1]), .addr_o(cb_addr)
    );

    arb_rr_n #(.N(2), .MODE(1), .SYNC_STAGES(2)) u_cc (
        .clk(clk), .n_rst(n_rst), .lni({cb_ro, ca_ro}), .n_lno(cc_nlno),
        .ro(cc_ro), .n_ri(cc_nri), .addr_o(cc_addr)
    );

    int total = 0;
    int bad   = 0;
    int model_p = 0;   // rotate pointer of the reference model for u_rr

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference winner: first requesting channel met when walking from p (rotate) or 0 (fixed).
    function automatic int model_winner(input logic [11:0] mask, input int p, input bit rr);
        int c;
        for (int k = 0; k < 12; k++) begin
            c = rr ? (p + k) % 12 : k;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic wait_ro(input int s, input logic val, input int budget, input string tag);
        int n;
        n = 0;
        while (ro_v[s] !== val && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, ro_v[s]}, {31'd0, val});
    endtask

    // Acts as requester g and as the upstream 4-phase responder for one full handshake.
    task automatic handshake(input int s, input int g, input string tag, input bit rearm);
        int n;
        logic [11:0] exp_nl;
        exp_nl    = 12'hFFF;
        exp_nl[g] = 1'b0;
        wait_ro(s, 1'b1, 40, {tag, "_ro_rise"});
        check({tag, "_addr"}, {28'd0, addr_v[s]}, g);
        check({tag, "_nlno_grant"}, {20'd0, nlno_v[s]}, 32'hFFF);
        n_ri_v[s] = 1'b0;
        n = 0;
        while (nlno_v[s] === 12'hFFF && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_nlno_ack"}, {20'd0, nlno_v[s]}, {20'd0, exp_nl});
        check({tag, "_ro_in_ack"}, {31'd0, ro_v[s]}, 32'd1);
        lni_v[s][g] = 1'b0;
        wait_ro(s, 1'b0, 20, {tag, "_ro_fall"});
        check({tag, "_nlno_release"}, {20'd0, nlno_v[s]}, 32'hFFF);
        n_ri_v[s] = 1'b1;
        if (rearm) lni_v[s][g] = 1'b1;
        if (s == 0) model_p = (g + 1) % 12;
    endtask

    initial begin
        int g;
        int cnt;
        logic [11:0] mask;
        int exp_rr [4];
        int phase [24];
        int left  [24];
        logic [23:0] req;
        logic [23:0] nl;
        int issued, done, overlap, badaddr, cyc;

        exp_rr[0] = 0; exp_rr[1] = 3; exp_rr[2] = 11; exp_rr[3] = 0;
        lni_v[0] = '0; lni_v[1] = '0; n_ri_v[0] = 1'b1; n_ri_v[1] = 1'b1;
        ca_lni = '0; cb_lni = '0; cc_nri = 1'b1;

        // Reset values, observed before any clock edge
        n_rst = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        check("rst_ro", {31'd0, ro_v[0]}, 32'd0);
        check("rst_nlno", {20'd0, nlno_v[0]}, 32'hFFF);
        check("rst_addr", {28'd0, addr_v[0]}, 32'd0);
        check("rst_fp_ro", {31'd0, ro_v[1]}, 32'd0);
        check("rst_cc_nlno", {30'd0, cc_nlno}, 32'd3);
        repeat (3) tick();
        n_rst = 1'b1;
        model_p = 0;
        repeat (4) tick();

        // Round-robin with 0, 3, 11 continuously requesting: wrap back to 0
        lni_v[0] = 12'h809;
        for (int k = 0; k < 4; k++) begin
            g = model_winner(lni_v[0], model_p, 1'b1);
            check("rr_model_order", g, exp_rr[k]);
            handshake(0, exp_rr[k], "rr_order", 1'b1);
        end
        lni_v[0] = '0;
        repeat (6) tick();

        // Fixed priority with the same stimulus: channel 0 every time
        lni_v[1] = 12'h809;
        for (int k = 0; k < 4; k++) handshake(1, 0, "fp_order", 1'b1);
        lni_v[1] = '0;
        repeat (6) tick();

        // Single request latency: ro rises exactly SYNC_STAGES+1 edges later
        lni_v[0] = 12'h020;
        tick(); tick();
        check("lat_early", {31'd0, ro_v[0]}, 32'd0);
        tick();
        check("lat_exact", {31'd0, ro_v[0]}, 32'd1);
        handshake(0, 5, "single", 1'b0);
        repeat (6) tick();

        // Stale upstream acknowledge blocks the grant until released
        n_ri_v[0] = 1'b0;
        repeat (3) tick();
        lni_v[0] = 12'h004;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (ro_v[0] === 1'b1) cnt++;
        end
        check("stale_ro_held", cnt, 0);
        n_ri_v[0] = 1'b1;
        handshake(0, 2, "stale_grant", 1'b0);
        repeat (6) tick();

        // Request withdrawn before ack: exactly one cycle with n_lno low
        lni_v[0] = 12'h080;
        wait_ro(0, 1'b1, 40, "early_ro_rise");
        n_ri_v[0] = 1'b0;
        lni_v[0] = '0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (nlno_v[0] !== 12'hFFF) begin
                cnt++;
                check("early_nlno_pat", {20'd0, nlno_v[0]}, 32'hF7F);
            end
        end
        check("early_ack_cycles", cnt, 1);
        check("early_ro_low", {31'd0, ro_v[0]}, 32'd0);
        n_ri_v[0] = 1'b1;
        model_p = 8;
        repeat (6) tick();

        // A request pulsing while busy is lost without trace
        lni_v[0] = 12'h002;
        wait_ro(0, 1'b1, 40, "lost_ro_rise");
        lni_v[0][9] = 1'b1;
        repeat (3) tick();
        lni_v[0][9] = 1'b0;
        handshake(0, 1, "lost_busy", 1'b0);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (ro_v[0] === 1'b1) cnt++;
        end
        check("lost_no_grant", cnt, 0);

        // Reset in ACK clears outputs at once; pointer restarts at 0
        lni_v[0] = 12'h020;
        wait_ro(0, 1'b1, 40, "rst_ack_ro");
        n_ri_v[0] = 1'b0;
        repeat (4) tick();
        check("rst_in_ack", {20'd0, nlno_v[0]}, 32'hFDF);
        #2 n_rst = 1'b0;
        #1;
        check("rst_async_ro", {31'd0, ro_v[0]}, 32'd0);
        check("rst_async_nlno", {20'd0, nlno_v[0]}, 32'hFFF);
        check("rst_async_addr", {28'd0, addr_v[0]}, 32'd0);
        n_ri_v[0] = 1'b1;
        lni_v[0] = 12'h808;
        model_p = 0;
        repeat (2) tick();
        n_rst = 1'b1;
        tick(); tick();
        check("rst_first_grant_late", {31'd0, ro_v[0]}, 32'd0);
        handshake(0, model_winner(12'h808, model_p, 1'b1), "rst_ptr", 1'b0);
        check("rst_ptr_winner", model_p, 4);
        lni_v[0] = '0;
        repeat (6) tick();

        // Random request sets against the reference model, both policies
        for (int r = 0; r < 24; r++) begin
            mask = 12'($urandom_range(1, 4095));
            lni_v[0] = mask;
            handshake(0, model_winner(mask, model_p, 1'b1), "rand_rr", 1'b0);
            lni_v[0] = '0;
            mask = 12'($urandom_range(1, 4095));
            lni_v[1] = mask;
            handshake(1, model_winner(mask, 0, 1'b0), "rand_fp", 1'b0);
            lni_v[1] = '0;
            repeat (5) tick();
        end

        // Cascade with 24 random 4-phase requesters and a random upstream responder
        issued = 0; done = 0; overlap = 0; badaddr = 0; cyc = 0;
        req = '0;
        for (int i = 0; i < 24; i++) begin
            phase[i] = 0;
            left[i]  = $urandom_range(1, 3);
            issued  += left[i];
        end
        while (done < issued && cyc < 20000) begin
            tick();
            cyc++;
            nl = {cb_nlno, ca_nlno};
            if ($countones(~nl) > 1) overlap++;
            if ($countones(~cc_nlno) > 1) overlap++;
            if ((ca_ro && ca_addr > 4'd11) || (cb_ro && cb_addr > 4'd11)) badaddr++;
            for (int i = 0; i < 24; i++) begin
                case (phase[i])
                    0: if (left[i] > 0 && $urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        phase[i] = 1;
                    end
                    1: if (!nl[i]) begin
                        req[i] = 1'b0;
                        phase[i] = 2;
                    end
                    default: if (nl[i]) begin
                        phase[i] = 0;
                        left[i]--;
                        done++;
                    end
                endcase
            end
            if (cc_ro && cc_nri) cc_nri = ($urandom_range(0, 1) == 1) ? 1'b0 : 1'b1;
            else if (!cc_ro && !cc_nri) cc_nri = 1'b1;
            ca_lni = req[11:0];
            cb_lni = req[23:12];
        end
        check("casc_all_complete", done, issued);
        check("casc_one_ack_low", overlap, 0);
        check("casc_addr_range", badaddr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
